// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and defaults for the fetch stage
package fetch_pkg;
    typedef enum logic {FETCH_IDLE, FETCH_WAIT} fetch_state_t;
    localparam int BUS_WIDTH_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam logic [BUS_WIDTH_DEF-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load-over-increment priority
module pc_reg #(
    parameter int ADDR_W = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    // taken jump beats increment; increment wraps naturally
    always_comb pc_d = load ? load_val : inc ? pc_q + ADDR_W'(1) : pc_q;
    // pc state register
    always_ff @(posedge clk or posedge reset)
        if (reset) pc_q <= ADDR_W'(RESET_PC);
        else pc_q <= pc_d;
    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, runs the imem handshake and holds the instruction register
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_inc,
    input  logic                 imem_read,
    input  logic                 jump,
    input  logic                 zero_flag,
    input  logic [ADDR_W-1:0]    jump_target,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [BUS_WIDTH-1:0] imem_rdata,
    input  logic                 imem_ack,
    output logic [BUS_WIDTH-1:0] ir,
    output logic                 ir_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 fetch_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    fetch_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic valid_q, valid_d, pend_q, pend_d, err_q, err_d;
    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .inc(pc_inc),
        .load(jump && !zero_flag),
        .load_val(jump_target),
        .pc(pc)
    );
    // fetch FSM: issue from IDLE, complete on ack or substitute a NOP on timeout
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        addr_d = addr_q;
        ir_d = ir_q;
        valid_d = 1'b0;
        pend_d = pend_q;
        err_d = err_q;
        if (state_q == FETCH_IDLE) begin
            if (imem_read || pend_q) begin
                state_d = FETCH_WAIT;
                addr_d = pc;
                timer_d = '0;
                pend_d = 1'b0;
            end
        end else begin
            pend_d = pend_q || imem_read;
            if (imem_ack) begin
                ir_d = imem_rdata;
                valid_d = 1'b1;
                state_d = FETCH_IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    ir_d = BUS_WIDTH'(NOP_INSTR);
                    valid_d = 1'b1;
                    err_d = 1'b1;
                    state_d = FETCH_IDLE;
                end
            end
        end
    end
    // fetch state registers; reset aborts any outstanding fetch
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= FETCH_IDLE;
            timer_q <= '0;
            addr_q <= ADDR_W'(RESET_PC);
            ir_q <= '0;
            valid_q <= 1'b0;
            pend_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q <= addr_d;
            ir_q <= ir_d;
            valid_q <= valid_d;
            pend_q <= pend_d;
            err_q <= err_d;
        end
    assign imem_req = state_q == FETCH_WAIT;
    assign imem_addr = addr_q;
    assign ir = ir_q;
    assign ir_valid = valid_q;
    assign busy = (state_q == FETCH_WAIT) || pend_q;
    assign fetch_err = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch handshake, PC update, pending, timeout and reset
module tb_fetch_unit;
    logic clk = 1'b0, reset = 1'b1;
    logic pc_inc = 1'b0, imem_read = 1'b0, jump = 1'b0, zero_flag = 1'b0, imem_ack = 1'b0;
    logic [7:0] jump_target = '0;
    logic [15:0] imem_rdata = '0;
    logic imem_req, ir_valid, busy, fetch_err;
    logic [7:0] imem_addr, pc;
    logic [15:0] ir;
    int total = 0, bad = 0, vcount = 0, v0 = 0;
    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_inc(pc_inc), .imem_read(imem_read), .jump(jump),
        .zero_flag(zero_flag), .jump_target(jump_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack), .ir(ir),
        .ir_valid(ir_valid), .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );
    always #5 clk = ~clk;
    // count ir_valid pulses away from the active edge
    always @(negedge clk) if (ir_valid) vcount++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        tick;
        tick;
        chk("rst_pc", pc, 8'h00);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_ir", ir, 16'h0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        reset = 1'b0;
        // zero-wait fetch
        imem_read = 1'b1;
        tick;
        imem_read = 1'b0;
        chk("zw_req", imem_req, 1'b1);
        chk("zw_addr", imem_addr, 8'h00);
        chk("zw_busy", busy, 1'b1);
        chk("zw_novalid", ir_valid, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 16'h1234;
        tick;
        imem_ack = 1'b0;
        chk("zw_ir", ir, 16'h1234);
        chk("zw_valid", ir_valid, 1'b1);
        chk("zw_req_done", imem_req, 1'b0);
        chk("zw_busy_done", busy, 1'b0);
        tick;
        chk("zw_pulse_end", ir_valid, 1'b0);
        chk("zw_ir_hold", ir, 16'h1234);
        // PC wrap and jump priority
        jump = 1'b1;
        jump_target = 8'hFF;
        tick;
        chk("pc_load_ff", pc, 8'hFF);
        jump = 1'b0;
        pc_inc = 1'b1;
        tick;
        chk("pc_wrap", pc, 8'h00);
        jump = 1'b1;
        zero_flag = 1'b1;
        jump_target = 8'h40;
        tick;
        chk("pc_jump_nz_blocked", pc, 8'h01);
        zero_flag = 1'b0;
        tick;
        chk("pc_jump_wins", pc, 8'h40);
        pc_inc = 1'b0;
        zero_flag = 1'b1;
        tick;
        chk("pc_jump_noop", pc, 8'h40);
        jump = 1'b0;
        zero_flag = 1'b0;
        // stray ack while idle
        imem_ack = 1'b1;
        imem_rdata = 16'hFFFF;
        tick;
        imem_ack = 1'b0;
        chk("stray_ir", ir, 16'h1234);
        chk("stray_valid", ir_valid, 1'b0);
        chk("stray_req", imem_req, 1'b0);
        // wait states with a pending second read and a pc_inc during WAIT
        v0 = vcount;
        imem_read = 1'b1;
        tick;
        chk("pd_addr1", imem_addr, 8'h40);
        pc_inc = 1'b1;
        tick;
        imem_read = 1'b0;
        pc_inc = 1'b0;
        chk("pd_pc", pc, 8'h41);
        chk("pd_addr_frozen", imem_addr, 8'h40);
        chk("pd_busy", busy, 1'b1);
        tick;
        chk("pd_still_req", imem_req, 1'b1);
        imem_ack = 1'b1;
        imem_rdata = 16'hABCD;
        tick;
        imem_ack = 1'b0;
        chk("pd_ir1", ir, 16'hABCD);
        chk("pd_valid1", ir_valid, 1'b1);
        chk("pd_req_drop", imem_req, 1'b0);
        chk("pd_busy_pend", busy, 1'b1);
        tick;
        chk("pd_req2", imem_req, 1'b1);
        chk("pd_addr2", imem_addr, 8'h41);
        chk("pd_gap", ir_valid, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 16'h5678;
        tick;
        imem_ack = 1'b0;
        chk("pd_ir2", ir, 16'h5678);
        chk("pd_busy_done", busy, 1'b0);
        tick;
        tick;
        chk("pd_pulses", vcount - v0, 2);
        chk("pd_idle", imem_req, 1'b0);
        // timeout with no ack
        imem_read = 1'b1;
        tick;
        imem_read = 1'b0;
        for (int i = 0; i < 14; i++) tick;
        chk("to_req_before", imem_req, 1'b1);
        chk("to_err_before", fetch_err, 1'b0);
        chk("to_valid_before", ir_valid, 1'b0);
        tick;
        chk("to_ir_nop", ir, 16'h0);
        chk("to_valid", ir_valid, 1'b1);
        chk("to_err", fetch_err, 1'b1);
        chk("to_req_drop", imem_req, 1'b0);
        tick;
        chk("to_err_sticky", fetch_err, 1'b1);
        imem_read = 1'b1;
        tick;
        imem_read = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        tick;
        imem_ack = 1'b0;
        chk("to_recover_ir", ir, 16'hBEEF);
        chk("to_recover_valid", ir_valid, 1'b1);
        chk("to_err_kept", fetch_err, 1'b1);
        // asynchronous reset in the middle of a fetch
        imem_read = 1'b1;
        tick;
        imem_read = 1'b0;
        chk("ar_req_pre", imem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", imem_req, 1'b0);
        chk("ar_pc", pc, 8'h00);
        chk("ar_ir", ir, 16'h0);
        chk("ar_err", fetch_err, 1'b0);
        chk("ar_busy", busy, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 16'h1111;
        tick;
        reset = 1'b0;
        tick;
        imem_ack = 1'b0;
        chk("ar_late_valid", ir_valid, 1'b0);
        chk("ar_late_ir", ir, 16'h0);
        chk("ar_late_req", imem_req, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
